// File: rtl/vga_scan_out.sv
// VGA scan-out stage: 640x480@60 timing from the 50 MHz clock, per-pixel
// colour requests to the frame store, and a fixed 4-CLK output pipeline so
// sync, blanking and colour for a pixel leave the block together.
module vga_scan_out #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic [11:0] pix_rgb,
  output logic        frame_st,
  output logic        vblank,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 10;
  localparam int unsigned OUT_DLY = 3 - RD_LAT;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
  localparam logic [CW-1:0] HS_ON   = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_OFF  = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON   = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_OFF  = CW'(V_VIS + V_FP + V_SYNC);
  localparam logic [1:0]    CAP_IDX = 2'(RD_LAT - 1);

  // {hs, vs, de} of an idle (disabled) timing point
  localparam logic [2:0]    TIM_IDLE = 3'b110;

  logic          pe;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;

  logic          vis_c;
  logic          req_c;
  logic          hs_c;
  logic          vs_c;

  logic [3:0][2:0]  tim_q;
  logic [2:0]       tag_q;
  logic [11:0]      col_q;
  logic [11:0]      col_next_c;
  logic [1:0][11:0] cdly_q;
  logic [11:0]      col_sel_c;

  // Pixel enable and free-running raster counters; held at origin while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe   <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      pe   <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
        end else begin
          hcnt <= hcnt + CW'(1);
        end
      end
    end
  end

  // Timing decode of the current raster point
  always_comb begin
    vis_c = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    req_c = en && pe && vis_c;
    hs_c  = ~((hcnt >= HS_ON) && (hcnt < HS_OFF));
    vs_c  = ~((vcnt >= VS_ON) && (vcnt < VS_OFF));
  end

  // Request port, frame strobe and renderer-side vblank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req  <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      frame_st <= 1'b0;
      vblank   <= 1'b0;
    end else begin
      pix_req  <= req_c;
      frame_st <= req_c && (hcnt == '0) && (vcnt == '0);
      vblank   <= (vcnt >= V_VIS_C);
      if (req_c) begin
        pix_x <= hcnt;
        pix_y <= vcnt[8:0];
      end
    end
  end

  // Sync/DE delay line; stage 0 loads once per pixel so the output steps with the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) tim_q[i] <= TIM_IDLE;
    end else begin
      if (!en) begin
        tim_q[0] <= TIM_IDLE;
      end else if (pe) begin
        tim_q[0] <= {hs_c, vs_c, vis_c};
      end
      for (int i = 1; i < 4; i++) tim_q[i] <= tim_q[i-1];
    end
  end

  // Colour captured on the tagged cycle, then padded so total latency stays at 4
  always_comb begin
    col_next_c = tag_q[CAP_IDX] ? pix_rgb : col_q;
    case (OUT_DLY)
      0:       col_sel_c = col_next_c;
      1:       col_sel_c = cdly_q[0];
      default: col_sel_c = cdly_q[1];
    endcase
  end

  // Request tag shift register and colour holding/padding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      col_q  <= '0;
      cdly_q <= '0;
    end else begin
      tag_q     <= {tag_q[1:0], pix_req};
      col_q     <= col_next_c;
      cdly_q[0] <= col_next_c;
      cdly_q[1] <= cdly_q[0];
    end
  end

  // Registered VGA pins; blanking forces black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= tim_q[3][2];
      vga_vs <= tim_q[3][1];
      {vga_r, vga_g, vga_b} <= tim_q[3][0] ? col_sel_c : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: one full-size instance plus three shrunken-geometry
// instances (RD_LAT 1..3) so frame wraps and vsync occur many times in a short run.
module tb_vga_scan_out;

  localparam int ND = 4;
  localparam logic [13:0] IDLE = 14'h3000;  // {hs=1, vs=1, rgb=0}

  // Geometry per instance: 0..7 = H_VIS,H_FP,H_SYNC,H_BP,V_VIS,V_FP,V_SYNC,V_BP; 8 = RD_LAT
  function automatic int geo(input int i, input int f);
    if (i == 0) begin
      case (f)
        0: return 640;  1: return 16; 2: return 96; 3: return 48;
        4: return 480;  5: return 10; 6: return 2;  7: return 33;
        8: return 2;
        default: return 0;
      endcase
    end
    case (f)
      0: return 16; 1: return 2; 2: return 4; 3: return 3;
      4: return 6;  5: return 2; 6: return 2; 7: return 3;
      8: return i;
      default: return 0;
    endcase
  endfunction

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        o_req [ND];
  logic [9:0]  o_x   [ND];
  logic [8:0]  o_y   [ND];
  logic        o_fs  [ND];
  logic        o_vb  [ND];
  logic        o_hs  [ND];
  logic        o_vs  [ND];
  logic [3:0]  o_r   [ND];
  logic [3:0]  o_g   [ND];
  logic [3:0]  o_b   [ND];
  logic [11:0] rgb_in[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vga_scan_out #(
      .H_VIS(geo(g,0)), .H_FP(geo(g,1)), .H_SYNC(geo(g,2)), .H_BP(geo(g,3)),
      .V_VIS(geo(g,4)), .V_FP(geo(g,5)), .V_SYNC(geo(g,6)), .V_BP(geo(g,7)),
      .RD_LAT(geo(g,8))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .pix_req(o_req[g]), .pix_x(o_x[g]), .pix_y(o_y[g]), .pix_rgb(rgb_in[g]),
      .frame_st(o_fs[g]), .vblank(o_vb[g]), .vga_hs(o_hs[g]), .vga_vs(o_vs[g]),
      .vga_r(o_r[g]), .vga_g(o_g[g]), .vga_b(o_b[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int          n;
  int          s;
  bit          running;
  logic [13:0] pipe    [ND][4];
  logic [13:0] exp_out [ND];
  logic        exp_req [ND];
  logic        exp_fs  [ND];
  logic        exp_vb  [ND];
  logic [9:0]  exp_x   [ND];
  logic [8:0]  exp_y   [ND];
  int          v_after [ND];
  logic        hreq    [ND][8];
  logic [9:0]  hx      [ND][8];
  logic [8:0]  hy      [ND][8];
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d edge %0d: observed %0h expected %0h", tag, i, n, obs, exp);
    end
  endtask

  // Raster model: pixel k of an enabled run is requested on edge s+1+2k and shown 4 edges later
  task automatic model_edge();
    if (!rst_n || !en) running = 1'b0;
    else if (!running) begin
      running = 1'b1;
      s = n;
    end
    for (int i = 0; i < ND; i++) begin
      int htot, vtot, q, k, h, v, hv, vv;
      bit vis;
      logic [13:0] p;
      hv   = geo(i,0);
      vv   = geo(i,4);
      htot = hv + geo(i,1) + geo(i,2) + geo(i,3);
      vtot = vv + geo(i,5) + geo(i,6) + geo(i,7);
      exp_req[i] = 1'b0;
      exp_fs[i]  = 1'b0;
      if (!rst_n) begin
        exp_vb[i]  = 1'b0;
        exp_x[i]   = '0;
        exp_y[i]   = '0;
        exp_out[i] = IDLE;
        v_after[i] = 0;
        for (int j = 0; j < 4; j++) pipe[i][j] = IDLE;
      end else begin
        exp_vb[i]  = (v_after[i] >= vv);
        exp_out[i] = pipe[i][3];
        for (int j = 3; j > 0; j--) pipe[i][j] = pipe[i][j-1];
        p = IDLE;
        if (running && n > s) begin
          q   = n - s;
          k   = ((q - 1) / 2) % (htot * vtot);
          h   = k % htot;
          v   = k / htot;
          vis = (h < hv) && (v < vv);
          p[13] = !((h >= hv + geo(i,1)) && (h < hv + geo(i,1) + geo(i,2)));
          p[12] = !((v >= vv + geo(i,5)) && (v < vv + geo(i,5) + geo(i,6)));
          p[11:0] = vis ? 12'((h ^ v) & 32'hFFF) : 12'h000;
          if (vis && (q % 2 == 1)) begin
            exp_req[i] = 1'b1;
            exp_fs[i]  = (k == 0);
            exp_x[i]   = 10'(h);
            exp_y[i]   = 9'(v);
          end
        end
        pipe[i][0] = p;
        v_after[i] = running ? ((((n + 1 - s) / 2) % (htot * vtot)) / htot) : 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < ND; i++) begin
      chk("pix_req",  i, 16'(o_req[i]), 16'(exp_req[i]));
      chk("pix_x",    i, 16'(o_x[i]),   16'(exp_x[i]));
      chk("pix_y",    i, 16'(o_y[i]),   16'(exp_y[i]));
      chk("frame_st", i, 16'(o_fs[i]),  16'(exp_fs[i]));
      chk("vblank",   i, 16'(o_vb[i]),  16'(exp_vb[i]));
      chk("vga_hs",   i, 16'(o_hs[i]),  16'(exp_out[i][13]));
      chk("vga_vs",   i, 16'(o_vs[i]),  16'(exp_out[i][12]));
      chk("vga_rgb",  i, 16'({o_r[i], o_g[i], o_b[i]}), 16'(exp_out[i][11:0]));
    end
  endtask

  // Renderer model: colour x^y is valid RD_LAT clocks after a request, noise otherwise
  task automatic drive_rgb();
    for (int i = 0; i < ND; i++) begin
      int lat, m;
      hreq[i][n % 8] = o_req[i];
      hx[i][n % 8]   = o_x[i];
      hy[i][n % 8]   = o_y[i];
      lat = geo(i,8);
      m   = n - lat;
      if (m >= 0 && hreq[i][m % 8])
        rgb_in[i] = 12'({2'b00, hx[i][m % 8]} ^ {3'b000, hy[i][m % 8]});
      else
        rgb_in[i] = 12'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check_all();
    drive_rgb();
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("rst_req", i, 16'(o_req[i]), 16'h0);
      chk("rst_hs",  i, 16'(o_hs[i]),  16'h1);
      chk("rst_vs",  i, 16'(o_vs[i]),  16'h1);
      chk("rst_rgb", i, 16'({o_r[i], o_g[i], o_b[i]}), 16'h0);
      chk("rst_xy",  i, 16'({o_x[i], o_y[i][5:0]}), 16'h0);
      chk("rst_fs",  i, 16'(o_fs[i]),  16'h0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n           = 0;
    s           = 0;
    running     = 1'b0;
    rst_n       = 1'b0;
    en          = 1'b0;
    for (int i = 0; i < ND; i++) begin
      rgb_in[i]  = '0;
      v_after[i] = 0;
      exp_x[i]   = '0;
      exp_y[i]   = '0;
      for (int j = 0; j < 4; j++) pipe[i][j] = IDLE;
      for (int j = 0; j < 8; j++) begin
        hreq[i][j] = 1'b0;
        hx[i][j]   = '0;
        hy[i][j]   = '0;
      end
    end

    repeat (3) step();
    rst_n = 1'b1;
    en    = 1'b1;

    // Reset mid-line around hcnt=300 on the full-size instance
    repeat (601) step();
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Uninterrupted run: many full lines, many small-geometry frame wraps
    repeat (30000) step();

    // Random enable drops and resets
    repeat (30) begin
      repeat ($urandom_range(1200, 100)) step();
      if ($urandom_range(9, 0) == 0) begin
        async_reset();
        repeat ($urandom_range(4, 1)) step();
        rst_n = 1'b1;
      end else begin
        en = 1'b0;
        repeat ($urandom_range(12, 1)) step();
        en = 1'b1;
      end
    end
    repeat (800) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
